// File: rtl/div_iter_if.sv
// div_iter_if: request/response bundle between the EX stage and the iterative divider
interface div_iter_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] res;
  modport master (output start, op, src0, src1, flush, input busy, done, res);
  modport slave  (input start, op, src0, src1, flush, output busy, done, res);
endinterface

// File: rtl/div_iter_unit.sv
// div_iter_unit: 32-cycle restoring divider for LA32R div.w/mod.w/div.wu/mod.wu
module div_iter_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
  input logic      clk,
  input logic      rstn,
  div_iter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a0_q, dvs_q, rem_q, quo_q, res_q;
  logic [4:0]       cnt_q;
  logic             sq_q, sr_q, div0_q, busy_q, done_q;
  logic             na, nb, take;
  logic [WIDTH-1:0] abs_a, abs_b, rem_sh, quo_n, rem_n, quot, remd;
  logic [WIDTH:0]   sum;
  // operand conditioning, the single trial-subtract adder and sign/div0 fix-up
  always_comb begin
    na     = ~op_q[1] & a0_q[WIDTH-1];
    nb     = ~op_q[1] & dvs_q[WIDTH-1];
    abs_a  = na ? ~a0_q + 1'b1 : a0_q;
    abs_b  = nb ? ~dvs_q + 1'b1 : dvs_q;
    rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    sum    = {1'b0, rem_sh} + {1'b0, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    // a bit shifted out of rem means the partial remainder already exceeds any divisor
    take   = sum[WIDTH] | rem_q[WIDTH-1];
    quo_n  = sq_q ? ~quo_q + 1'b1 : quo_q;
    rem_n  = sr_q ? ~rem_q + 1'b1 : rem_q;
    quot   = div0_q ? DIV0_QUOT : quo_n;
    remd   = div0_q ? a0_q : rem_n;
  end
  // control FSM with registered busy/done/res; flush aborts any non-idle state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= '0;
      a0_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && bus.flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (bus.start && !bus.flush) begin
            state_q <= PREP;
            busy_q  <= 1'b1;
            op_q    <= bus.op;
            a0_q    <= bus.src0;
            dvs_q   <= bus.src1;
          end
          PREP: begin
            quo_q   <= abs_a;
            dvs_q   <= abs_b;
            rem_q   <= '0;
            sq_q    <= na ^ nb;
            sr_q    <= na;
            div0_q  <= dvs_q == '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
          CALC: begin
            rem_q   <= take ? sum[WIDTH-1:0] : rem_sh;
            quo_q   <= {quo_q[WIDTH-2:0], take};
            cnt_q   <= cnt_q + 5'd1;
            state_q <= cnt_q == 5'd31 ? FIX : CALC;
          end
          FIX: begin
            res_q   <= op_q[0] ? remd : quot;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: scoreboard bench for div_iter_unit against an arithmetic reference
module tb_div_iter_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int tests = 0;
  int fails = 0;
  int phase = 0;
  logic [31:0] pend = '0;
  logic [31:0] m_res = '0;
  logic [31:0] sb_q[$];
  div_iter_if bus();
  div_iter_unit dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  // compare and log
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: plain signed/unsigned division with LA32R div-by-zero results
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 0) return op[0] ? a : 32'hFFFF_FFFF;
    if (!op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[0] ? r : q;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  // behavioural model: phase counts edges since acceptance (1..35 busy, 35 = done)
  task automatic model_edge();
    if (!rstn) return;
    if (phase == 0) begin
      if (bus.start && !bus.flush) begin
        pend = ref_res(bus.op, bus.src0, bus.src1);
        sb_q.push_back(pend);
        phase = 1;
      end
    end else if (bus.flush) begin
      if (phase != 35 && sb_q.size() != 0) void'(sb_q.pop_back());
      phase = 0;
    end else if (phase == 35) phase = 0;
    else begin
      phase++;
      if (phase == 35) m_res = pend;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask
  task automatic model_reset();
    phase = 0;
    m_res = '0;
    sb_q.delete();
  endtask
  // monitor: timing of busy/done, held result, and scoreboard pop on done
  always @(negedge clk) begin
    if (rstn) begin
      check("busy", 32'(bus.busy), 32'(phase != 0));
      check("done", 32'(bus.done), 32'(phase == 35));
      check("res_hold", bus.res, m_res);
      if (bus.done) begin
        if (sb_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("sb_res", bus.res, sb_q.pop_front());
      end
    end
  end
  task automatic wait_idle();
    for (int i = 0; i < 40 && phase != 0; i++) step();
  endtask
  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int k;
    wait_idle();
    bus.start = 1'b1; bus.op = op; bus.src0 = a; bus.src1 = b;
    step();
    bus.start = 1'b0;
    for (k = 1; k <= 50; k++) begin
      step();
      if (bus.done) break;
    end
    check({name, "_lat"}, 32'(k), 32'd34);
    check(name, bus.res, exp);
    step();
  endtask
  initial begin
    bus.start = 1'b0; bus.op = '0; bus.src0 = '0; bus.src1 = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", bus.res, 32'd0);
    rstn = 1'b1;
    run("divw_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run("modw_100_m7", 2'b01, 32'd100, 32'hFFFF_FFF9, 32'd2);
    run("modw_m100_7", 2'b01, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    run("divwu_max_2", 2'b10, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
    run("divw_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("modw_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run("divwu_5_0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("modwu_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
    run("modw_m5_0", 2'b01, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run("divw_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run("divwu_big", 2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0);
    run("modwu_big", 2'b11, 32'hFFFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFD);
    // flush mid-operation: no done, result keeps its previous value
    bus.start = 1'b1; bus.op = 2'b00; bus.src0 = 32'd1000; bus.src1 = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_res", bus.res, 32'h7FFF_FFFD);
    step();
    check("flush_nodone", 32'(bus.done), 32'd0);
    run("after_flush", 2'b11, 32'd1000, 32'd7, 32'd6);
    // asynchronous reset mid-operation
    bus.start = 1'b1; bus.op = 2'b10; bus.src0 = 32'd77; bus.src1 = 32'd5;
    step();
    bus.start = 1'b0;
    repeat (19) step();
    rstn = 1'b0;
    model_reset();
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_res", bus.res, 32'd0);
    repeat (2) step();
    rstn = 1'b1;
    run("after_rst", 2'b10, 32'd77, 32'd5, 32'd15);
    // random traffic: starts while busy, back-to-back issue, flush in any state
    for (int i = 0; i < 40000; i++) begin
      step();
      bus.start = $urandom_range(0, 2) != 0;
      bus.flush = $urandom_range(0, 199) == 0;
      bus.op    = 2'($urandom_range(0, 3));
      bus.src0  = pick();
      bus.src1  = pick();
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    wait_idle();
    repeat (2) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
